// File: rtl/system_ocm_copy_master_pkg.sv
// system_ocm_pkg: shared definitions for the OCM copy/fill master.
//   - FSM state encoding for the copy master
//   - OCM geometry (128 x 32-bit words)
//   - byte-enable constant and word->byte address helper
package system_ocm_pkg;

  localparam int unsigned OCM_WORDS       = 128;
  localparam int unsigned OCM_WORD_ADDR_W = 7;
  localparam int unsigned DATA_W          = 32;
  localparam logic [DATA_W/8-1:0] BYTEEN_ALL = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_FINISH
  } ocm_state_t;

  // Byte address of an OCM word as seen by the master port.
  function automatic logic [31:0] word_to_byte_addr(input logic [31:0] base,
                                                     input logic [31:0] word_idx);
    return base + (word_idx << 2);
  endfunction

endpackage

// File: rtl/system_ocm_copy_master_if.sv
// system_ocm_copy_master_if: Avalon-MM master bus between the copy master
// and the interconnect (OCM s2 port).
//   master modport: address, read, write, byteenable, writedata out;
//                   readdata, readdatavalid, waitrequest in.
//   slave modport : the mirror image.
interface system_ocm_copy_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                waitrequest;

  modport master (
    output address, read, write, byteenable, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/system_ocm_addr_ctr.sv
// system_ocm_addr_ctr: wrapping OCM word pointer.
//   clk, reset_n : clock, asynchronous active-low reset (pointer -> 0)
//   load         : load load_val (has priority over inc)
//   load_val     : starting word index
//   inc          : advance by one word, wrapping at 2^W
//   value        : current word index
module system_ocm_addr_ctr
  import system_ocm_pkg::*;
#(
  parameter int unsigned W = OCM_WORD_ADDR_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] value
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (inc) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/system_ocm_copy_master.sv
// system_ocm_copy_master: Avalon-MM initiator on the OCM s2 port performing
// word block copies or pattern fills on command.
//   clk, reset_n      : clock, asynchronous active-low reset
//   start             : command strobe (ignored unless idle)
//   mode_fill         : 0 = copy, 1 = fill (sampled on start)
//   src_word/dst_word : source / destination word index (sampled on start)
//   len               : word count, 0 completes with no bus traffic
//   fill_data         : fill pattern (sampled on start)
//   abort             : stop after the word in flight completes
//   busy, done        : command in progress / one-cycle completion pulse
//   aborted           : sticky, last command ended by abort
//   words_done        : words written in current/last command
//   avm               : Avalon-MM master bus (one transaction outstanding)
module system_ocm_copy_master #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WORD_ADDR_W = 7,
  parameter int unsigned LEN_W       = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   mode_fill,
  input  logic [WORD_ADDR_W-1:0] src_word,
  input  logic [WORD_ADDR_W-1:0] dst_word,
  input  logic [LEN_W-1:0]       len,
  input  logic [DATA_W-1:0]      fill_data,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic [LEN_W-1:0]       words_done,
  system_ocm_copy_master_if.master avm
);
  import system_ocm_pkg::*;

  ocm_state_t state_q, state_d;

  logic                   mode_fill_q;
  logic [LEN_W-1:0]       len_q;
  logic [LEN_W-1:0]       words_done_q;
  logic                   abort_pend_q;
  logic                   aborted_q;
  logic [DATA_W-1:0]      wdata_q;
  logic [WORD_ADDR_W-1:0] src_ptr;
  logic [WORD_ADDR_W-1:0] dst_ptr;
  logic [ADDR_W-1:0]      addr_d;

  logic accept;
  logic wr_acc;
  logic rd_cap;
  logic last_word;
  logic abort_hit;

  assign accept    = (state_q == ST_IDLE) && start;
  assign wr_acc    = (state_q == ST_WR_REQ) && !avm.waitrequest;
  assign rd_cap    = (state_q == ST_RD_WAIT) && avm.readdatavalid;
  assign last_word = (words_done_q + LEN_W'(1)) == len_q;
  // An abort arriving in the same cycle as the write acceptance counts too.
  assign abort_hit = abort_pend_q || abort;

  system_ocm_addr_ctr #(.W(WORD_ADDR_W)) u_src_ctr (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (accept),
    .load_val (src_word),
    .inc      (wr_acc),
    .value    (src_ptr)
  );

  system_ocm_addr_ctr #(.W(WORD_ADDR_W)) u_dst_ctr (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (accept),
    .load_val (dst_word),
    .inc      (wr_acc),
    .value    (dst_ptr)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len == '0) begin
            state_d = ST_FINISH;
          end else if (mode_fill) begin
            state_d = ST_WR_REQ;
          end else begin
            state_d = ST_RD_REQ;
          end
        end
      end
      ST_RD_REQ: begin
        if (!avm.waitrequest) begin
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (avm.readdatavalid) begin
          state_d = ST_WR_REQ;
        end
      end
      ST_WR_REQ: begin
        if (!avm.waitrequest) begin
          if (last_word || abort_hit) begin
            state_d = ST_FINISH;
          end else if (mode_fill_q) begin
            state_d = ST_WR_REQ;
          end else begin
            state_d = ST_RD_REQ;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_fill_q  <= 1'b0;
      len_q        <= '0;
      words_done_q <= '0;
      abort_pend_q <= 1'b0;
      aborted_q    <= 1'b0;
      wdata_q      <= '0;
    end else if (accept) begin
      mode_fill_q  <= mode_fill;
      len_q        <= len;
      words_done_q <= '0;
      abort_pend_q <= 1'b0;
      aborted_q    <= 1'b0;
      // Copies overwrite this with read data before the first write.
      wdata_q      <= fill_data;
    end else begin
      if (busy && abort) begin
        abort_pend_q <= 1'b1;
      end
      if (rd_cap) begin
        wdata_q <= avm.readdata;
      end
      if (wr_acc) begin
        words_done_q <= words_done_q + LEN_W'(1);
        if (!last_word && abort_hit) begin
          aborted_q <= 1'b1;
        end
      end
    end
  end

  // Address is only driven while a request is up; zero otherwise.
  always_comb begin
    addr_d = '0;
    if (state_q == ST_RD_REQ) begin
      addr_d = ADDR_W'(word_to_byte_addr(BASE_ADDR, 32'(src_ptr)));
    end else if (state_q == ST_WR_REQ) begin
      addr_d = ADDR_W'(word_to_byte_addr(BASE_ADDR, 32'(dst_ptr)));
    end
  end

  assign busy       = (state_q == ST_RD_REQ) || (state_q == ST_RD_WAIT) ||
                      (state_q == ST_WR_REQ);
  assign done       = (state_q == ST_FINISH);
  assign aborted    = aborted_q;
  assign words_done = words_done_q;

  assign avm.address    = addr_d;
  assign avm.read       = (state_q == ST_RD_REQ);
  assign avm.write      = (state_q == ST_WR_REQ);
  assign avm.byteenable = '1;
  assign avm.writedata  = wdata_q;

endmodule

// File: tb/tb_system_ocm_copy_master.sv
module tb_system_ocm_copy_master;
  import system_ocm_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        mode_fill = 1'b0;
  logic [6:0]  src_word = '0;
  logic [6:0]  dst_word = '0;
  logic [7:0]  len = '0;
  logic [31:0] fill_data = '0;
  logic        abort = 1'b0;
  logic        busy, done, aborted;
  logic [7:0]  words_done;

  always #5 clk = ~clk;

  system_ocm_copy_master_if #(.ADDR_W(32), .DATA_W(32)) avm_if ();

  system_ocm_copy_master #(
    .DATA_W(32), .WORD_ADDR_W(7), .LEN_W(8), .BASE_ADDR(32'h0), .ADDR_W(32)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode_fill(mode_fill),
    .src_word(src_word), .dst_word(dst_word), .len(len), .fill_data(fill_data),
    .abort(abort), .busy(busy), .done(done), .aborted(aborted),
    .words_done(words_done), .avm(avm_if)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Behavioural OCM slave with optional stalls and read latency.
  logic [31:0] mem     [128];
  logic [31:0] exp_mem [128];
  bit          stall_en = 0;
  int          wait_left = 0;
  bit          rd_pend = 0;
  int          rd_delay = 0;
  logic [6:0]  rd_idx;
  int          rd_count = 0, wr_count = 0, req_seen = 0;
  logic [31:0] wr_addr_log [$];
  logic [31:0] wr_data_log [$];
  int          wr_cyc_log  [$];
  bit          stall_flag = 0;
  logic        snap_read, snap_write;
  logic [31:0] snap_addr, snap_wdata;
  int          proto_viol = 0;

  initial begin
    avm_if.readdata      = '0;
    avm_if.readdatavalid = 1'b0;
    avm_if.waitrequest   = 1'b0;
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset_n) begin
      wait_left = 0; rd_pend = 0; stall_flag = 0;
      avm_if.readdatavalid = 1'b0;
      avm_if.waitrequest   = 1'b0;
    end else begin
      if (rd_pend) begin
        if (rd_delay == 0) begin
          avm_if.readdatavalid = 1'b1;
          avm_if.readdata      = mem[rd_idx];
          rd_pend = 0;
        end else begin
          rd_delay--;
          avm_if.readdatavalid = 1'b0;
        end
      end else begin
        avm_if.readdatavalid = 1'b0;
        avm_if.readdata      = $urandom;
      end
      if (avm_if.read || avm_if.write) begin
        req_seen++;
        if (wait_left > 0) begin
          wait_left--;
          avm_if.waitrequest = 1'b1;
          stall_flag = 1;
          snap_read  = avm_if.read;
          snap_write = avm_if.write;
          snap_addr  = avm_if.address;
          snap_wdata = avm_if.writedata;
        end else begin
          avm_if.waitrequest = 1'b0;
          stall_flag = 0;
          if (avm_if.write) begin
            mem[avm_if.address[8:2]] = avm_if.writedata;
            wr_count++;
            wr_addr_log.push_back(avm_if.address);
            wr_data_log.push_back(avm_if.writedata);
            wr_cyc_log.push_back(cyc);
          end else begin
            rd_pend  = 1;
            rd_delay = stall_en ? int'($urandom_range(0, 2)) : 0;
            rd_idx   = avm_if.address[8:2];
            rd_count++;
          end
          wait_left = stall_en ? int'($urandom_range(0, 5)) : 0;
        end
      end else begin
        avm_if.waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
        stall_flag = 0;
      end
    end
  end

  // Protocol monitor: requests stable under stall, never read and write together.
  always @(posedge clk) begin
    #1;
    if (reset_n) begin
      if (avm_if.read && avm_if.write) proto_viol++;
      if (avm_if.byteenable !== BYTEEN_ALL) proto_viol++;
      if (stall_flag && (avm_if.read !== snap_read || avm_if.write !== snap_write ||
                         avm_if.address !== snap_addr ||
                         (snap_write && avm_if.writedata !== snap_wdata)))
        proto_viol++;
    end
  end

  task automatic randomize_mem();
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
  endtask

  // Reference: words move strictly in ascending order, pointers wrap at 128.
  task automatic model_cmd(input bit f, input int s, input int d, input int n,
                           input logic [31:0] pat);
    for (int i = 0; i < n; i++)
      exp_mem[(d + i) % 128] = f ? pat : exp_mem[(s + i) % 128];
  endtask

  task automatic issue(input bit f, input int s, input int d, input int n,
                       input logic [31:0] pat, output int scyc);
    @(negedge clk);
    mode_fill = f; src_word = 7'(s); dst_word = 7'(d); len = 8'(n);
    fill_data = pat; start = 1'b1; scyc = cyc;
    @(negedge clk);
    start = 1'b0;
    mode_fill = 1'($urandom); src_word = 7'($urandom); dst_word = 7'($urandom);
    len = 8'($urandom); fill_data = $urandom;
  endtask

  task automatic wait_done(input int max_cyc, output int dcyc, output bit ok);
    ok = 0; dcyc = 0;
    for (int i = 0; i < max_cyc; i++) begin
      if (done === 1'b1) begin ok = 1; dcyc = cyc; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL reset_aborted got %b want 0", aborted); end
    checks++; if (avm_if.read !== 1'b0 || avm_if.write !== 1'b0) begin
      errors++; $display("FAIL reset_req got rd=%b wr=%b want 0/0", avm_if.read, avm_if.write); end
    checks++; if (words_done !== 8'd0) begin errors++; $display("FAIL reset_words got %0d want 0", words_done); end
    checks++; if (avm_if.address !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", avm_if.address); end
    checks++; if (avm_if.writedata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", avm_if.writedata); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_copy_nowait();
    int scyc, dcyc, rcyc; bit ok;
    stall_en = 0;
    randomize_mem();
    exp_mem = mem;
    model_cmd(0, 10, 40, 4, 32'h0);
    issue(0, 10, 40, 4, 32'h0, scyc);
    rcyc = cyc;
    checks++; if (avm_if.read !== 1'b1 || avm_if.address !== 32'd40) begin
      errors++; $display("FAIL copy_first_req got rd=%b addr=%h want 1/028", avm_if.read, avm_if.address); end
    wait_done(100, dcyc, ok);
    checks++; if (!ok || dcyc - rcyc != 12) begin
      errors++; $display("FAIL copy_done_latency got ok=%0d cycles=%0d want 12", ok, dcyc - rcyc); end
    checks++; if (busy !== 1'b0 || words_done !== 8'd4 || aborted !== 1'b0) begin
      errors++; $display("FAIL copy_status got busy=%b words=%0d ab=%b want 0/4/0", busy, words_done, aborted); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL copy_done_pulse got %b want 0", done); end
    for (int i = 0; i < 128; i++) begin
      checks++; if (mem[i] !== exp_mem[i]) begin
        errors++; $display("FAIL copy_mem word %0d got %h want %h", i, mem[i], exp_mem[i]); end
    end
  endtask

  task automatic test_fill_wrap();
    int scyc, dcyc; bit ok;
    logic [31:0] exp_addr [4];
    stall_en = 0;
    exp_addr[0] = 32'h1F8; exp_addr[1] = 32'h1FC; exp_addr[2] = 32'h000; exp_addr[3] = 32'h004;
    wr_addr_log.delete(); wr_data_log.delete(); wr_cyc_log.delete();
    exp_mem = mem;
    model_cmd(1, 0, 126, 4, 32'hDEADBEEF);
    issue(1, $urandom_range(0, 127), 126, 4, 32'hDEADBEEF, scyc);
    wait_done(50, dcyc, ok);
    checks++; if (!ok || wr_addr_log.size() != 4) begin
      errors++; $display("FAIL fill_count got ok=%0d writes=%0d want 4", ok, wr_addr_log.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (wr_addr_log[i] !== exp_addr[i] || wr_data_log[i] !== 32'hDEADBEEF ||
                      wr_cyc_log[i] != scyc + 1 + i) begin
          errors++; $display("FAIL fill_write %0d got addr=%h data=%h cyc=%0d want %h/deadbeef/%0d",
                             i, wr_addr_log[i], wr_data_log[i], wr_cyc_log[i], exp_addr[i], scyc + 1 + i);
        end
      end
      checks++; if (dcyc != wr_cyc_log[3] + 1) begin
        errors++; $display("FAIL fill_done_latency got %0d want %0d", dcyc, wr_cyc_log[3] + 1); end
    end
    checks++; if (words_done !== 8'd4) begin errors++; $display("FAIL fill_words got %0d want 4", words_done); end
    for (int i = 0; i < 128; i++) begin
      checks++; if (mem[i] !== exp_mem[i]) begin
        errors++; $display("FAIL fill_mem word %0d got %h want %h", i, mem[i], exp_mem[i]); end
    end
  endtask

  task automatic test_random_stalls();
    int scyc, dcyc, rd0, s, d, n; bit ok, f; logic [31:0] pat;
    stall_en = 1;
    proto_viol = 0;
    for (int it = 0; it < 10; it++) begin
      f = 1'($urandom_range(0, 1));
      s = $urandom_range(0, 127); d = $urandom_range(0, 127);
      n = (it == 9) ? 128 : int'($urandom_range(1, 24));
      pat = $urandom;
      randomize_mem();
      exp_mem = mem;
      model_cmd(f, s, d, n, pat);
      rd0 = rd_count;
      issue(f, s, d, n, pat, scyc);
      wait_done(n * 40 + 40, dcyc, ok);
      checks++; if (!ok || words_done !== 8'(n)) begin
        errors++; $display("FAIL stall_words it=%0d got ok=%0d words=%0d want %0d", it, ok, words_done, n); end
      checks++; if (rd_count - rd0 != (f ? 0 : n)) begin
        errors++; $display("FAIL stall_reads it=%0d got %0d want %0d", it, rd_count - rd0, f ? 0 : n); end
      for (int i = 0; i < 128; i++) begin
        checks++; if (mem[i] !== exp_mem[i]) begin
          errors++; $display("FAIL stall_mem it=%0d word %0d got %h want %h", it, i, mem[i], exp_mem[i]); end
      end
    end
    checks++; if (proto_viol != 0) begin
      errors++; $display("FAIL stall_protocol got %0d violations want 0", proto_viol); end
    stall_en = 0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_len_zero();
    int scyc, dcyc, req0; bit ok;
    stall_en = 0;
    exp_mem = mem;
    req0 = req_seen;
    issue(0, 3, 9, 0, 32'h0, scyc);
    wait_done(20, dcyc, ok);
    checks++; if (!ok || dcyc != scyc + 1) begin
      errors++; $display("FAIL len0_done got ok=%0d at +%0d want +1", ok, dcyc - scyc); end
    repeat (6) @(negedge clk);
    checks++; if (req_seen != req0) begin
      errors++; $display("FAIL len0_no_bus got %0d requests want 0", req_seen - req0); end
    checks++; if (words_done !== 8'd0 || aborted !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL len0_status got words=%0d ab=%b busy=%b want 0/0/0", words_done, aborted, busy); end
    checks++; if (mem != exp_mem) begin errors++; $display("FAIL len0_mem got changed memory want unchanged"); end
  endtask

  task automatic test_abort();
    int scyc, dcyc, rd0, wr0; bit ok, hit;
    stall_en = 0;
    randomize_mem();
    exp_mem = mem;
    model_cmd(0, 0, 64, 5, 32'h0);
    rd0 = rd_count; wr0 = wr_count; hit = 0;
    issue(0, 0, 64, 20, 32'h0, scyc);
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge clk); #1;
      if (rd_count - rd0 == 5 && wr_count - wr0 == 4 && busy && !avm_if.read && !avm_if.write) begin
        abort = 1'b1; hit = 1;
        @(posedge clk); #1;
        abort = 1'b0;
      end
    end
    checks++; if (!hit) begin errors++; $display("FAIL abort_window got none want 5th read wait"); end
    wait_done(200, dcyc, ok);
    checks++; if (!ok || words_done !== 8'd5 || aborted !== 1'b1) begin
      errors++; $display("FAIL abort_status got ok=%0d words=%0d ab=%b want 5/1", ok, words_done, aborted); end
    repeat (4) @(negedge clk);
    checks++; if (aborted !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_sticky got ab=%b busy=%b want 1/0", aborted, busy); end
    for (int i = 0; i < 128; i++) begin
      checks++; if (mem[i] !== exp_mem[i]) begin
        errors++; $display("FAIL abort_mem word %0d got %h want %h", i, mem[i], exp_mem[i]); end
    end
  endtask

  task automatic test_abort_idle();
    int scyc, dcyc; bit ok;
    stall_en = 0;
    exp_mem = mem;
    model_cmd(0, 100, 20, 3, 32'h0);
    @(negedge clk);
    abort = 1'b1;
    repeat (3) @(negedge clk);
    issue(0, 100, 20, 3, 32'h0, scyc);
    abort = 1'b0;
    checks++; if (aborted !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL idle_abort_clear got ab=%b busy=%b want 0/1", aborted, busy); end
    wait_done(60, dcyc, ok);
    checks++; if (!ok || words_done !== 8'd3 || aborted !== 1'b0) begin
      errors++; $display("FAIL idle_abort_status got ok=%0d words=%0d ab=%b want 3/0", ok, words_done, aborted); end
    checks++; if (mem != exp_mem) begin errors++; $display("FAIL idle_abort_mem got wrong memory want model"); end
  endtask

  task automatic test_start_while_busy();
    int scyc, s2, dcyc; bit ok;
    stall_en = 0;
    randomize_mem();
    exp_mem = mem;
    model_cmd(0, 5, 60, 6, 32'h0);
    issue(0, 5, 60, 6, 32'h0, scyc);
    repeat (3) @(negedge clk);
    issue(1, 0, 100, 10, 32'h12345678, s2);
    wait_done(80, dcyc, ok);
    checks++; if (!ok || words_done !== 8'd6 || dcyc != scyc + 19) begin
      errors++; $display("FAIL busy_start_first got ok=%0d words=%0d at +%0d want 6 at +19", ok, words_done, dcyc - scyc); end
    repeat (12) @(negedge clk);
    checks++; if (busy !== 1'b0 || words_done !== 8'd6) begin
      errors++; $display("FAIL busy_start_ignored got busy=%b words=%0d want 0/6", busy, words_done); end
    for (int i = 0; i < 128; i++) begin
      checks++; if (mem[i] !== exp_mem[i]) begin
        errors++; $display("FAIL busy_start_mem word %0d got %h want %h", i, mem[i], exp_mem[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int scyc, wr0; bit seen;
    stall_en = 0;
    wr0 = wr_count; seen = 0;
    issue(1, 0, 20, 10, 32'hA5A5_0F0F, scyc);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (wr_count - wr0 >= 3) seen = 1;
    end
    @(posedge clk); #1;
    checks++; if (avm_if.write !== 1'b1 || !seen) begin
      errors++; $display("FAIL rstmid_pre got wr=%b want 1", avm_if.write); end
    reset_n = 1'b0;
    #1;
    checks++; if (avm_if.write !== 1'b0 || avm_if.read !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
                  words_done !== 8'd0 || avm_if.address !== 32'h0 || avm_if.writedata !== 32'h0 ||
                  aborted !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs got wr=%b rd=%b busy=%b words=%0d addr=%h wd=%h want all 0",
                         avm_if.write, avm_if.read, busy, words_done, avm_if.address, avm_if.writedata);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b0 || wr_count - wr0 >= 10) begin
      errors++; $display("FAIL rstmid_after got busy=%b writes=%0d want 0/<10", busy, wr_count - wr0); end
  endtask

  initial begin
    test_reset();
    test_copy_nowait();
    test_fill_wrap();
    test_len_zero();
    test_abort();
    test_abort_idle();
    test_start_while_busy();
    test_random_stalls();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
